volatility_scheduler: RTL and testbench
=======================================

# volatility_scheduler

Front-end sequencer for the per-stock volatility ring-buffer memory. It arbitrates best-bid/best-ask updates from several market-data requesters round-robin and owns the per-stock circular write pointers. It issues one registered write per cycle (valid, flat address, stock id, prices) to the memory, tracks per-stock warm-up (window full), and runs a flush sequence that zeroes one stock's window through the normal write path so its moving sums return to zero.

## Interface
- DATA_WIDTH, 32, price width
- BUFFER_SIZE, 20, samples per stock window
- NUM_STOCKS, 4, number of stock windows
- NUM_REQ, 2, number of update requesters
- SW = $clog2(NUM_STOCKS), AW = $clog2(NUM_STOCKS*BUFFER_SIZE) (derived)

Ports:
- i_clk  in  1  clock
- i_reset_n  in  1  reset, synchronous, active-low
- i_req_valid  in  NUM_REQ  per-requester update valid
- i_req_stock_id  in  NUM_REQ×SW  per-requester stock id
- i_req_best_ask  in  NUM_REQ×DATA_WIDTH  per-requester best ask
- i_req_best_bid  in  NUM_REQ×DATA_WIDTH  per-requester best bid
- o_req_ready  out  NUM_REQ  one-hot grant; transfer when valid&ready
- i_flush_valid  in  1  flush request
- i_flush_stock_id  in  SW  stock to flush
- o_flush_ready  out  1  flush accepted when valid&ready
- o_mem_valid  out  1  memory write strobe
- o_mem_write_address  out  AW  flat address = stock*BUFFER_SIZE + ptr
- o_mem_stock_id  out  SW  stock of this write
- o_mem_best_ask  out  DATA_WIDTH  ask for this write
- o_mem_best_bid  out  DATA_WIDTH  bid for this write
- o_warm  out  NUM_STOCKS  per-stock window full

## Operation
- State: RUN, FLUSH. Reset state is RUN.
- Per-stock state: ptr[s] in 0..BUFFER_SIZE-1; fill[s] in 0..BUFFER_SIZE, saturating. RR pointer rr in 0..NUM_REQ-1.
- RUN, no flush: grant goes to the first valid requester scanning rr, rr+1, … mod NUM_REQ. o_req_ready is high only for that requester and is combinational from i_req_valid and state. On transfer, rr becomes winner+1 mod NUM_REQ.
- Accepted update for stock s < NUM_STOCKS:
  - Register one write: address s*BUFFER_SIZE+ptr[s], inputs passed unmodified.
  - ptr[s] wraps BUFFER_SIZE-1 → 0.
  - fill[s]++ (saturates).
- Accepted update with stock id ≥ NUM_STOCKS: the handshake completes and rr advances. No write is issued and no state changes.
- Flush priority: when i_flush_valid and state RUN, o_flush_ready=1 and all o_req_ready=0 that cycle; the flush wins.
- On flush accept, latch stock f and set index k=0, then enter FLUSH.
- FLUSH:
  - Each cycle issues a write at f*BUFFER_SIZE+ptr[f] with ask=bid=0, advances ptr[f], and increments k.
  - After BUFFER_SIZE writes, return to RUN.
  - ptr[f] ends equal to its start value. fill[f]=0 and o_warm[f]=0 from the first flush write onward.
  - o_req_ready=0 and o_flush_ready=0 throughout FLUSH.
  - A flush of stock id ≥ NUM_STOCKS is accepted and completes immediately with no writes.
- o_warm[s] = (fill[s]==BUFFER_SIZE), registered.

## Timing
- Reset: all outputs 0 (o_mem_*, o_warm, o_flush_ready=0 during reset); ptr, fill, rr, k = 0; state RUN. Reset during FLUSH aborts it.
- Update accepted at cycle t → o_mem_* valid at t+1, a single-cycle pulse. o_warm reflects the write at t+1.
- Throughput: one update per cycle in RUN. Back-to-back updates to the same stock get consecutive addresses.
- Flush accepted at t → FLUSH during t+1..t+BUFFER_SIZE; o_mem_valid high t+2..t+BUFFER_SIZE+1.
- RUN resumes at t+BUFFER_SIZE+1. o_req_ready can be high at t+BUFFER_SIZE+1; that update is written at t+BUFFER_SIZE+2, with no gap or overlap.
- o_mem_valid=0 on cycles with no accepted update and no flush write.

## Test plan
- Single requester, 21 updates to stock 2 (defaults):
  - Addresses 40,41,…,59, then 40.
  - o_warm[2] rises the cycle the 20th write appears; other warm bits stay 0.
- Both requesters valid every cycle (stock 0 vs stock 1):
  - Grants alternate 0,1,0,1 starting with 0.
  - Writes alternate addresses 0,20,1,21,…; one write per cycle.
- Flush stock 1 after 7 updates:
  - 20 zero writes at addresses 27..39, 20..26.
  - fill and o_warm[1] = 0; o_req_ready low for 20 cycles.
  - The next stock-1 update goes to address 27.
- Flush and update asserted in the same cycle: flush wins, the update is stalled, and it is written at accept+22.
- Reset asserted mid-flush (after 5 zero writes):
  - Outputs 0 next cycle; all pointers 0.
  - First post-reset stock-3 update goes to address 60.
- Update with stock id ≥ NUM_STOCKS (NUM_STOCKS=3, id 3):
  - Handshake completes and rr advances.
  - o_mem_valid stays 0.

Source files
------------

// File: rtl/volatility_scheduler_if.sv
// Request, flush and memory-write bundle for the volatility scheduler.
interface volatility_scheduler_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int BUFFER_SIZE = 20,
    parameter int NUM_STOCKS  = 4,
    parameter int NUM_REQ     = 2
);
    localparam int SW = $clog2(NUM_STOCKS);
    localparam int AW = $clog2(NUM_STOCKS * BUFFER_SIZE);

    logic [NUM_REQ-1:0]                 i_req_valid;
    logic [NUM_REQ-1:0][SW-1:0]         i_req_stock_id;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] i_req_best_ask;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] i_req_best_bid;
    logic [NUM_REQ-1:0]                 o_req_ready;
    logic                               i_flush_valid;
    logic [SW-1:0]                      i_flush_stock_id;
    logic                               o_flush_ready;
    logic                               o_mem_valid;
    logic [AW-1:0]                      o_mem_write_address;
    logic [SW-1:0]                      o_mem_stock_id;
    logic [DATA_WIDTH-1:0]              o_mem_best_ask;
    logic [DATA_WIDTH-1:0]              o_mem_best_bid;
    logic [NUM_STOCKS-1:0]              o_warm;

    modport slave (
        input  i_req_valid, i_req_stock_id, i_req_best_ask, i_req_best_bid,
        input  i_flush_valid, i_flush_stock_id,
        output o_req_ready, o_flush_ready,
        output o_mem_valid, o_mem_write_address, o_mem_stock_id,
        output o_mem_best_ask, o_mem_best_bid, o_warm
    );

    modport master (
        output i_req_valid, i_req_stock_id, i_req_best_ask, i_req_best_bid,
        output i_flush_valid, i_flush_stock_id,
        input  o_req_ready, o_flush_ready,
        input  o_mem_valid, o_mem_write_address, o_mem_stock_id,
        input  o_mem_best_ask, o_mem_best_bid, o_warm
    );
endinterface

// File: rtl/volatility_scheduler.sv
// Volatility ring-buffer write sequencer: round-robin update arbitration,
// per-stock circular write pointers, warm-up tracking and window flush.
module volatility_scheduler #(
    parameter int DATA_WIDTH  = 32,
    parameter int BUFFER_SIZE = 20,
    parameter int NUM_STOCKS  = 4,
    parameter int NUM_REQ     = 2
) (
    input logic                   i_clk,
    input logic                   i_reset_n,
    volatility_scheduler_if.slave bus
);
    localparam int SW = $clog2(NUM_STOCKS);
    localparam int AW = $clog2(NUM_STOCKS * BUFFER_SIZE);
    localparam int PW = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1;
    localparam int FW = $clog2(BUFFER_SIZE + 1);
    localparam int RW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {RUN, FLUSH} state_t;

    state_t                state, state_nxt;
    logic [RW-1:0]         rr, rr_nxt, win, idx;
    logic [PW-1:0]         k, k_nxt;
    logic [SW-1:0]         fs, fs_nxt, sel_s;
    logic [PW-1:0]         ptr [NUM_STOCKS];
    logic [PW-1:0]         ptr_nxt [NUM_STOCKS];
    logic [FW-1:0]         fill [NUM_STOCKS];
    logic [FW-1:0]         fill_nxt [NUM_STOCKS];
    logic [NUM_REQ-1:0]    grant;
    logic                  flush_rdy, found;
    logic                  wr_v;
    logic [SW-1:0]         wr_s;
    logic [PW-1:0]         wr_p;
    logic [DATA_WIDTH-1:0] wr_ask, wr_bid;
    logic [AW-1:0]         wr_addr;

    logic                  mem_v_q;
    logic [AW-1:0]         addr_q;
    logic [SW-1:0]         stock_q;
    logic [DATA_WIDTH-1:0] ask_q, bid_q;
    logic [NUM_STOCKS-1:0] warm_q;

    always_comb begin
        state_nxt = state;
        rr_nxt    = rr;
        k_nxt     = k;
        fs_nxt    = fs;
        ptr_nxt   = ptr;
        fill_nxt  = fill;
        grant     = '0;
        flush_rdy = 1'b0;
        found     = 1'b0;
        win       = '0;
        idx       = '0;
        sel_s     = '0;
        wr_v      = 1'b0;
        wr_s      = '0;
        wr_p      = '0;
        wr_ask    = '0;
        wr_bid    = '0;
        unique case (state)
            RUN: begin
                if (bus.i_flush_valid) begin
                    flush_rdy = 1'b1;
                    // Out-of-range flush ids are consumed without any writes.
                    if (32'(bus.i_flush_stock_id) < 32'(NUM_STOCKS)) begin
                        state_nxt = FLUSH;
                        fs_nxt    = bus.i_flush_stock_id;
                        k_nxt     = '0;
                    end
                end else begin
                    for (int i = 0; i < NUM_REQ; i++) begin
                        idx = RW'((int'(rr) + i) % NUM_REQ);
                        if (!found && bus.i_req_valid[idx]) begin
                            found = 1'b1;
                            win   = idx;
                        end
                    end
                    if (found) begin
                        grant[win] = 1'b1;
                        rr_nxt = (win == RW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
                        sel_s  = bus.i_req_stock_id[win];
                        if (32'(sel_s) < 32'(NUM_STOCKS)) begin
                            wr_v   = 1'b1;
                            wr_s   = sel_s;
                            wr_p   = ptr[sel_s];
                            wr_ask = bus.i_req_best_ask[win];
                            wr_bid = bus.i_req_best_bid[win];
                            ptr_nxt[sel_s] = (ptr[sel_s] == PW'(BUFFER_SIZE - 1))
                                           ? '0 : ptr[sel_s] + 1'b1;
                            fill_nxt[sel_s] = (fill[sel_s] == FW'(BUFFER_SIZE))
                                            ? fill[sel_s] : fill[sel_s] + 1'b1;
                        end
                    end
                end
            end
            FLUSH: begin
                // Zero writes walk the whole ring, so ptr ends where it began.
                wr_v         = 1'b1;
                wr_s         = fs;
                wr_p         = ptr[fs];
                ptr_nxt[fs]  = (ptr[fs] == PW'(BUFFER_SIZE - 1)) ? '0 : ptr[fs] + 1'b1;
                fill_nxt[fs] = '0;
                k_nxt        = k + 1'b1;
                if (k == PW'(BUFFER_SIZE - 1)) state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    assign wr_addr = AW'(wr_s) * AW'(BUFFER_SIZE) + AW'(wr_p);

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state   <= RUN;
            rr      <= '0;
            k       <= '0;
            fs      <= '0;
            mem_v_q <= 1'b0;
            addr_q  <= '0;
            stock_q <= '0;
            ask_q   <= '0;
            bid_q   <= '0;
            warm_q  <= '0;
            for (int s = 0; s < NUM_STOCKS; s++) begin
                ptr[s]  <= '0;
                fill[s] <= '0;
            end
        end else begin
            state   <= state_nxt;
            rr      <= rr_nxt;
            k       <= k_nxt;
            fs      <= fs_nxt;
            mem_v_q <= wr_v;
            addr_q  <= wr_addr;
            stock_q <= wr_s;
            ask_q   <= wr_ask;
            bid_q   <= wr_bid;
            for (int s = 0; s < NUM_STOCKS; s++) begin
                ptr[s]    <= ptr_nxt[s];
                fill[s]   <= fill_nxt[s];
                warm_q[s] <= (fill_nxt[s] == FW'(BUFFER_SIZE));
            end
        end
    end

    assign bus.o_req_ready         = i_reset_n ? grant : '0;
    assign bus.o_flush_ready       = i_reset_n & flush_rdy;
    assign bus.o_mem_valid         = mem_v_q;
    assign bus.o_mem_write_address = addr_q;
    assign bus.o_mem_stock_id      = stock_q;
    assign bus.o_mem_best_ask      = ask_q;
    assign bus.o_mem_best_bid      = bid_q;
    assign bus.o_warm              = warm_q;
endmodule

// File: tb/tb_volatility_scheduler.sv
// Scoreboard bench for volatility_scheduler: directed updates, arbitration,
// flush, reset-in-flush and out-of-range stock ids.
module tb_volatility_scheduler;
    typedef struct {
        int addr;
        int stock;
        int ask;
        int bid;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_err = 0;
    exp_t q[$];
    exp_t q3[$];
    exp_t me, me3;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    volatility_scheduler_if #(
        .DATA_WIDTH(32), .BUFFER_SIZE(20), .NUM_STOCKS(4), .NUM_REQ(2)
    ) bus ();
    volatility_scheduler_if #(
        .DATA_WIDTH(32), .BUFFER_SIZE(20), .NUM_STOCKS(3), .NUM_REQ(2)
    ) bus3 ();

    volatility_scheduler #(
        .DATA_WIDTH(32), .BUFFER_SIZE(20), .NUM_STOCKS(4), .NUM_REQ(2)
    ) u_dut (.i_clk(clk), .i_reset_n(rst_n), .bus(bus));

    volatility_scheduler #(
        .DATA_WIDTH(32), .BUFFER_SIZE(20), .NUM_STOCKS(3), .NUM_REQ(2)
    ) u_dut3 (.i_clk(clk), .i_reset_n(rst_n), .bus(bus3));

    task automatic check(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (bus.o_mem_valid === 1'b1) begin
            if (q.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                me = q.pop_front();
                check("mem_addr", bus.o_mem_write_address, me.addr);
                check("mem_stock", bus.o_mem_stock_id, me.stock);
                check("mem_ask", bus.o_mem_best_ask, me.ask);
                check("mem_bid", bus.o_mem_best_bid, me.bid);
                check("mem_cycle", cyc, me.cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (bus3.o_mem_valid === 1'b1) begin
            if (q3.size() == 0) begin
                check("unexpected_write3", 1, 0);
            end else begin
                me3 = q3.pop_front();
                check("mem3_addr", bus3.o_mem_write_address, me3.addr);
                check("mem3_ask", bus3.o_mem_best_ask, me3.ask);
                check("mem3_cycle", cyc, me3.cyc);
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        bus.i_flush_valid = 1'b1;
        bus.i_req_valid = 2'b11;
        @(posedge clk);
        @(negedge clk);
        check("rst_mem_valid", bus.o_mem_valid, 0);
        check("rst_addr", bus.o_mem_write_address, 0);
        check("rst_ask", bus.o_mem_best_ask, 0);
        check("rst_warm", bus.o_warm, 0);
        check("rst_req_ready", bus.o_req_ready, 0);
        check("rst_flush_ready", bus.o_flush_ready, 0);
        @(posedge clk);
        #1;
        bus.i_flush_valid = 1'b0;
        bus.i_req_valid = 2'b00;
        rst_n = 1'b1;
    endtask

    task automatic upd(input int r, input int s, input int a, input int b, input int addr);
        bit ok = 1'b0;
        bus.i_req_valid[r] = 1'b1;
        bus.i_req_stock_id[r] = 2'(s);
        bus.i_req_best_ask[r] = 32'(a);
        bus.i_req_best_bid[r] = 32'(b);
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = bus.o_req_ready[r];
        end
        check("upd_grant", ok, 1);
        if (ok) q.push_back('{addr, s, a, b, cyc + 1});
        @(posedge clk);
        #1;
        bus.i_req_valid[r] = 1'b0;
    endtask

    task automatic flush(input int s, output int t);
        bit ok = 1'b0;
        bus.i_flush_valid = 1'b1;
        bus.i_flush_stock_id = 2'(s);
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = bus.o_flush_ready;
        end
        check("flush_accept", ok, 1);
        t = cyc;
        check("flush_blocks_req", bus.o_req_ready, 0);
        @(posedge clk);
        #1;
        bus.i_flush_valid = 1'b0;
    endtask

    initial begin
        int t;
        bit ok;
        bus.i_req_valid = '0;
        bus.i_req_stock_id = '0;
        bus.i_req_best_ask = '0;
        bus.i_req_best_bid = '0;
        bus.i_flush_valid = 1'b0;
        bus.i_flush_stock_id = '0;
        bus3.i_req_valid = '0;
        bus3.i_req_stock_id = '0;
        bus3.i_req_best_ask = '0;
        bus3.i_req_best_bid = '0;
        bus3.i_flush_valid = 1'b0;
        bus3.i_flush_stock_id = '0;
        do_reset();

        // 21 updates to stock 2: ring wrap and warm-up
        for (int i = 0; i < 21; i++) begin
            upd(0, 2, 1000 + i, 900 + i, 40 + i % 20);
            check("warm_stock2", bus.o_warm, (i >= 19) ? 4 : 0);
        end

        // Out-of-range stock id on the 3-stock instance
        bus3.i_req_valid = 2'b01;
        bus3.i_req_stock_id[0] = 2'd3;
        @(negedge clk);
        check("bad_id_grant", bus3.o_req_ready, 1);
        @(posedge clk);
        #1;
        bus3.i_req_valid = 2'b11;
        bus3.i_req_stock_id[0] = 2'd0;
        bus3.i_req_stock_id[1] = 2'd0;
        bus3.i_req_best_ask[1] = 32'd55;
        bus3.i_req_best_bid[1] = 32'd56;
        @(negedge clk);
        check("bad_id_no_write", bus3.o_mem_valid, 0);
        check("bad_id_rr_adv", bus3.o_req_ready, 2);
        q3.push_back('{0, 0, 55, 56, cyc + 1});
        @(posedge clk);
        #1;
        bus3.i_req_valid = 2'b00;

        // Two requesters contending every cycle
        do_reset();
        bus.i_req_valid = 2'b11;
        bus.i_req_stock_id[0] = 2'd0;
        bus.i_req_stock_id[1] = 2'd1;
        for (int c = 0; c < 8; c++) begin
            bus.i_req_best_ask[0] = 32'(100 + c);
            bus.i_req_best_bid[0] = 32'(150 + c);
            bus.i_req_best_ask[1] = 32'(200 + c);
            bus.i_req_best_bid[1] = 32'(250 + c);
            @(negedge clk);
            check("rr_grant", bus.o_req_ready, (c % 2 == 0) ? 1 : 2);
            if (c % 2 == 0) q.push_back('{c / 2, 0, 100 + c, 150 + c, cyc + 1});
            else q.push_back('{20 + c / 2, 1, 200 + c, 250 + c, cyc + 1});
            @(posedge clk);
            #1;
        end
        bus.i_req_valid = 2'b00;

        // Flush stock 1 after 7 updates, requester waiting behind it
        do_reset();
        for (int i = 0; i < 7; i++) upd(0, 1, 300 + i, 301 + i, 20 + i);
        flush(1, t);
        for (int j = 0; j < 20; j++) q.push_back('{20 + (7 + j) % 20, 1, 0, 0, t + 2 + j});
        bus.i_req_valid[0] = 1'b1;
        bus.i_req_stock_id[0] = 2'd1;
        bus.i_req_best_ask[0] = 32'd777;
        bus.i_req_best_bid[0] = 32'd778;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            check("flush_req_low", bus.o_req_ready, 0);
        end
        @(negedge clk);
        check("post_flush_grant", bus.o_req_ready, 1);
        check("post_flush_cyc", cyc, t + 21);
        q.push_back('{27, 1, 777, 778, cyc + 1});
        @(posedge clk);
        #1;
        bus.i_req_valid[0] = 1'b0;
        check("flush_warm", bus.o_warm, 0);
        for (int j = 0; j < 19; j++) begin
            upd(0, 1, 500 + j, 501 + j, 20 + (8 + j) % 20);
            check("refill_warm", bus.o_warm, (j == 18) ? 2 : 0);
        end

        // Flush and update in the same cycle
        do_reset();
        bus.i_flush_valid = 1'b1;
        bus.i_flush_stock_id = 2'd0;
        bus.i_req_valid[0] = 1'b1;
        bus.i_req_stock_id[0] = 2'd2;
        bus.i_req_best_ask[0] = 32'd42;
        bus.i_req_best_bid[0] = 32'd43;
        @(negedge clk);
        check("tie_flush_ready", bus.o_flush_ready, 1);
        check("tie_req_ready", bus.o_req_ready, 0);
        t = cyc;
        for (int j = 0; j < 20; j++) q.push_back('{j, 0, 0, 0, t + 2 + j});
        @(posedge clk);
        #1;
        bus.i_flush_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = bus.o_req_ready[0];
        end
        check("stall_grant", ok, 1);
        check("stall_accept_cyc", cyc, t + 21);
        if (ok) q.push_back('{40, 2, 42, 43, cyc + 1});
        @(posedge clk);
        #1;
        bus.i_req_valid[0] = 1'b0;

        // Reset after 5 zero writes of a stock-3 flush
        do_reset();
        for (int i = 0; i < 3; i++) upd(1, 3, 600 + i, 650 + i, 60 + i);
        flush(3, t);
        for (int j = 0; j < 5; j++) q.push_back('{63 + j, 3, 0, 0, t + 2 + j});
        repeat (5) @(posedge clk);
        #1;
        do_reset();
        upd(0, 3, 700, 701, 60);
        upd(1, 0, 710, 711, 0);

        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_drained", q.size(), 0);
        check("scoreboard3_drained", q3.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
